alu_control_fsm: RTL and testbench

- Multi-cycle control unit that drives the ALU's operation-select/enable side of the interface and consumes its n/z/o flag outputs.
- Sequences FETCH/DECODE/EXEC/MEM/WB for the 16-bit RISC-Z datapath.
- Latches ALU flags into a status register and evaluates conditional branches.
- Sits between instruction memory/IR and the datapath: register file, PC, ALU, data memory.

---
 rtl/alu_control_fsm_pkg.sv | 41 ++++
 rtl/alu_control_fsm_branch_cond.sv | 15 +
 rtl/alu_control_fsm.sv | 110 +++++++++++
 tb/tb_alu_control_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_fsm_pkg.sv
// alu_control_fsm_pkg: state, opcode, ALU-op and flag encodings shared by the RISC-Z control unit.
package alu_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_MOV  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_NAND = 4'h3,
    ALU_OR   = 4'h4,
    ALU_SUB  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SLA  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9
  } alu_op_e;

  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BRZ  = 4'hC;
  localparam logic [3:0] OP_BRN  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_O = 0;

  function automatic logic is_alu_op(input logic [3:0] opc);
    return opc <= ALU_SRA;
  endfunction

endpackage

// File: rtl/alu_control_fsm_branch_cond.sv
// alu_control_fsm_branch_cond: decides whether a control-transfer opcode redirects the PC.
module alu_control_fsm_branch_cond
  import alu_control_fsm_pkg::*;
(
  input  logic [3:0] opc,
  input  logic [2:0] flags,
  output logic       taken
);

  always_comb
    taken = ((opc == OP_BRZ) & flags[FLAG_Z]) |
            ((opc == OP_BRN) & flags[FLAG_N]) |
            (opc == OP_JMP);

endmodule

// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC-Z datapath.
module alu_control_fsm
  import alu_control_fsm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_o,
  output logic              alu_enable,
  output logic [OPC_W-1:0]  alu_op,
  output logic              alu_src_imm,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_data_sel,
  output logic              reg_write,
  output logic              wb_sel,
  output logic [2:0]        flags,
  output logic              halted
);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [2:0]         flags_q, flags_d;
  logic               init_q, init_d;
  logic               fetch, exec, mem, wb, alu_cls, lw, sw, ls, taken;
  logic               unused_instr;

  assign unused_instr = ^instr[DATA_W-OPC_W-1:0];

  // The cycle right after reset release is a quiet one: no fetch is issued.
  assign fetch   = !init_q & (state_q == S_FETCH);
  assign exec    = state_q == S_EXEC;
  assign mem     = state_q == S_MEM;
  assign wb      = state_q == S_WB;
  assign alu_cls = is_alu_op(opc_q);
  assign lw      = opc_q == OP_LW;
  assign sw      = opc_q == OP_SW;
  assign ls      = lw | sw;

  alu_control_fsm_branch_cond u_branch_cond (
    .opc   (opc_q),
    .flags (flags_q),
    .taken (taken)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    flags_d = flags_q;
    init_d  = 1'b0;
    if (!init_q)
      unique case (state_q)
        S_FETCH: if (mem_ready) begin
          opc_d   = instr[DATA_W-1 -: OPC_W];
          state_d = S_DECODE;
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          if (alu_cls) begin
            flags_d[FLAG_N] = alu_n;
            flags_d[FLAG_Z] = alu_z;
            flags_d[FLAG_O] = alu_o;
          end
          state_d = alu_cls ? S_WB : ls ? S_MEM : (opc_q == OP_HALT) ? S_HALT : S_FETCH;
        end
        S_MEM:   state_d = mem_ready ? S_FETCH : S_MEM;
        S_WB:    state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      flags_q <= '0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      flags_q <= flags_d;
      init_q  <= init_d;
    end

  // Address generation for LW/SW stays on the ALU through MEM so the address is stable during waits.
  assign alu_enable   = exec & (alu_cls | ls);
  assign alu_op       = (exec & alu_cls) ? opc_q : ((exec | mem) & ls) ? ALU_ADD : '0;
  assign alu_src_imm  = (exec | mem) & ls;
  assign ir_load      = fetch & mem_ready;
  assign pc_inc       = fetch & mem_ready;
  assign pc_load      = exec & taken;
  assign mem_read     = fetch | (mem & lw);
  assign mem_write    = mem & sw;
  assign mem_data_sel = mem;
  assign reg_write    = wb | (mem & lw & mem_ready);
  assign wb_sel       = mem & lw & mem_ready;
  assign flags        = flags_q;
  assign halted       = state_q == S_HALT;

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb_alu_control_fsm: instruction-level reference model plus table, random and corner-case sequences.
module tb_alu_control_fsm;

  typedef struct packed {
    logic       en;
    logic [3:0] op;
    logic       imm, irl, pci, pcl, mrd, mwr, msel, rw, wbs;
    logic [2:0] fl;
    logic       hlt;
  } outs_t;

  typedef struct {
    logic [15:0] ins;
    int          fw;
    int          mw;
    logic [2:0]  nzo;
    bit          taken;
    logic [2:0]  fl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        alu_n = 1'b0, alu_z = 1'b0, alu_o = 1'b0;
  logic        alu_enable, alu_src_imm, ir_load, pc_inc, pc_load;
  logic        mem_read, mem_write, mem_data_sel, reg_write, wb_sel, halted;
  logic [3:0]  alu_op;
  logic [2:0]  flags;

  outs_t obs, smp;
  logic [2:0] mflags;
  int checks = 0;
  int errors = 0;
  vec_t tv[12];

  always #5 clk = ~clk;

  alu_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .alu_n(alu_n), .alu_z(alu_z), .alu_o(alu_o),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_sel(mem_data_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .flags(flags), .halted(halted)
  );

  assign obs = {alu_enable, alu_op, alu_src_imm, ir_load, pc_inc, pc_load, mem_read,
                mem_write, mem_data_sel, reg_write, wb_sel, flags, halted};

  function automatic outs_t base();
    outs_t e = '0;
    e.fl = mflags;
    return e;
  endfunction

  task automatic chk(input string nm, input outs_t e, input outs_t m);
    if (!e.rw) m.wbs = 1'b0;
    checks++;
    if ((obs & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (care %05h) at %0t", nm, obs, e, m, $time);
    end
    checks++;
    if ((obs.mrd & obs.mwr) | (obs.pci & obs.pcl) | (obs.rw & obs.pcl)) begin
      errors++;
      $display("FAIL %s exclusive strobes: got %05h at %0t", nm, obs, $time);
    end
  endtask

  task automatic cyc(input string nm, input outs_t e, input outs_t m);
    @(negedge clk);
    chk(nm, e, m);
    smp = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    outs_t z = '0;
    reset = 1'b1;
    mflags = '0;
    #1;
    chk("reset_async", z, '1);
    cyc("reset_hold", z, '1);
    reset = 1'b0;
    mem_ready = 1'b1;
    instr = 16'h1123;
    cyc("reset_first_cycle", z, '1);
  endtask

  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic [2:0] nzo, input bit abort_mem, output bit taken);
    logic [3:0] opc = ins[15:12];
    bit is_lw = opc == 4'hA;
    bit is_ls = opc == 4'hA || opc == 4'hB;
    outs_t e, m;
    taken = 1'b0;
    for (int i = 0; i < fw; i++) begin
      instr = 16'($urandom);
      mem_ready = 1'b0;
      e = base(); e.mrd = 1'b1;
      cyc("fetch_wait", e, '1);
    end
    instr = ins;
    mem_ready = 1'b1;
    e = base(); e.mrd = 1'b1; e.irl = 1'b1; e.pci = 1'b1;
    cyc("fetch", e, '1);
    instr = 16'($urandom);
    mem_ready = 1'($urandom);
    {alu_n, alu_z, alu_o} = 3'($urandom);
    cyc("decode", base(), '1);
    {alu_n, alu_z, alu_o} = nzo;
    mem_ready = 1'($urandom);
    e = base(); m = '1;
    if (opc <= 4'h9) begin
      e.en = 1'b1; e.op = opc;
    end else if (is_ls) begin
      e.en = 1'b1; e.op = 4'h1; e.imm = 1'b1;
    end else begin
      m.en = 1'b0;
      e.pcl = (opc == 4'hC) ? mflags[1] : (opc == 4'hD) ? mflags[2] : (opc == 4'hE);
    end
    cyc("exec", e, m);
    taken = smp.pcl;
    {alu_n, alu_z, alu_o} = 3'($urandom);
    if (opc <= 4'h9) begin
      mflags = nzo;
      e = base(); e.rw = 1'b1;
      cyc("writeback", e, '1);
    end else if (is_ls) begin
      e = base(); e.msel = 1'b1; e.op = 4'h1; e.mrd = is_lw; e.mwr = !is_lw;
      m = '1; m.imm = 1'b0;
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        if (abort_mem) begin
          @(negedge clk);
          chk("mem_before_abort", e, m);
          #2;
          do_reset();
          return;
        end
        cyc("mem_wait", e, m);
      end
      mem_ready = 1'b1;
      e.rw = is_lw; e.wbs = is_lw;
      cyc("mem_done", e, m);
    end
  endtask

  initial begin
    bit tk;
    outs_t e;
    tv[0]  = '{16'h1123, 0, 0, 3'b010, 1'b0, 3'b010};
    tv[1]  = '{16'hC005, 0, 0, 3'b000, 1'b1, 3'b010};
    tv[2]  = '{16'h5123, 0, 0, 3'b000, 1'b0, 3'b000};
    tv[3]  = '{16'hD003, 0, 0, 3'b111, 1'b0, 3'b000};
    tv[4]  = '{16'h4321, 0, 0, 3'b101, 1'b0, 3'b101};
    tv[5]  = '{16'hB214, 2, 0, 3'b010, 1'b0, 3'b101};
    tv[6]  = '{16'hA214, 0, 3, 3'b011, 1'b0, 3'b101};
    tv[7]  = '{16'hD001, 0, 0, 3'b000, 1'b1, 3'b101};
    tv[8]  = '{16'hC001, 0, 0, 3'b010, 1'b0, 3'b101};
    tv[9]  = '{16'hE000, 1, 0, 3'b000, 1'b1, 3'b101};
    tv[10] = '{16'h0100, 0, 0, 3'b011, 1'b0, 3'b011};
    tv[11] = '{16'h9000, 1, 0, 3'b110, 1'b0, 3'b110};
    mflags = '0;
    #2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_instr(tv[i].ins, tv[i].fw, tv[i].mw, tv[i].nzo, 1'b0, tk);
      checks++;
      if (tk !== tv[i].taken || flags !== tv[i].fl) begin
        errors++;
        $display("FAIL vec%0d: taken %0b flags %03b, expected taken %0b flags %03b",
                 i, tk, flags, tv[i].taken, tv[i].fl);
      end
    end
    for (int i = 0; i < 150; i++) begin
      logic [3:0] opc = 4'($urandom_range(0, 14));
      run_instr({opc, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3),
                3'($urandom), 1'b0, tk);
    end
    run_instr(16'h2345, 0, 0, 3'b111, 1'b0, tk);
    run_instr(16'hB214, 0, 2, 3'b000, 1'b1, tk);
    run_instr(16'hC000, 0, 0, 3'b000, 1'b0, tk);
    checks++;
    if (tk !== 1'b0) begin
      errors++;
      $display("FAIL brz_after_reset: taken %0b expected 0", tk);
    end
    run_instr(16'hF000, 0, 0, 3'b101, 1'b0, tk);
    e = base(); e.hlt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'b1;
      instr = 16'($urandom);
      cyc("halt_idle", e, '1);
    end
    do_reset();
    run_instr(16'h1123, 0, 0, 3'b100, 1'b0, tk);
    checks++;
    if (flags !== 3'b100) begin
      errors++;
      $display("FAIL resume_after_halt: flags %03b expected 100", flags);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
